// File: rtl/phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// | Module   : phase_sequencer_if                                           |
// | Brief    : Run/stop controls in, phase/status out of the phase sequencer.|
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

interface phase_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             exec;
  logic [15:0]      instruction;
  logic             step_mode;
  logic [2:0]       phase;
  logic             running;
  logic             stop_flag;
  logic [CNT_W-1:0] retired;

  // master: front panel / IR side; slave: the sequencer itself
  modport master (
    output exec, instruction, step_mode,
    input  phase, running, stop_flag, retired
  );

  modport slave (
    input  exec, instruction, step_mode,
    output phase, running, stop_flag, retired
  );
endinterface

`default_nettype wire

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// | Module   : phase_sequencer                                              |
// | Brief    : Multicycle phase generator, run/stop control, retire count.  |
// |            Optional single-step: define PHASE_SEQ_SINGLE_STEP_EN.       |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
`default_nettype none

module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W      = 16
) (
  input  wire                     clk,
  input  wire                     rst,
  phase_sequencer_if.slave        sif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES);

  logic [0:0]       state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic             exec_q, exec_d;
  logic             stop_pending_q, stop_pending_d;
  logic             stop_flag_q, stop_flag_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic exec_rise;
  logic is_hlt;
  logic step_stop;

  assign exec_rise = sif.exec & ~exec_q;
  assign is_hlt    = (sif.instruction[15:14] == 2'b11) && (sif.instruction[7:4] == 4'b1111);

`ifdef PHASE_SEQ_SINGLE_STEP_EN
  assign step_stop = sif.step_mode;
  logic unused_bits;
  assign unused_bits = ^{sif.instruction[13:8], sif.instruction[3:0]};
`else
  assign step_stop = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{sif.step_mode, sif.instruction[13:8], sif.instruction[3:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      phase_q        <= 3'd0;
      exec_q         <= 1'b0;
      stop_pending_q <= 1'b0;
      stop_flag_q    <= 1'b0;
      retired_q      <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      exec_q         <= exec_d;
      stop_pending_q <= stop_pending_d;
      stop_flag_q    <= stop_flag_d;
      retired_q      <= retired_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    exec_d         = sif.exec;
    stop_pending_d = stop_pending_q;
    stop_flag_d    = 1'b0;
    retired_d      = retired_q;

    case (state_q)
      ST_IDLE: begin
        stop_pending_d = 1'b0;
        if (exec_rise) begin
          state_d = ST_RUN;
          phase_d = 3'd1;
        end
      end
      default: begin
        if ((phase_q == 3'd0) || (phase_q > LAST_PHASE)) begin
          // Corrupted phase: park in idle rather than run off the end
          state_d        = ST_IDLE;
          phase_d        = 3'd0;
          stop_pending_d = 1'b0;
        end else if (phase_q != LAST_PHASE) begin
          phase_d = phase_q + 3'd1;
          if (exec_rise) begin
            stop_pending_d = 1'b1;
          end
        end else begin
          retired_d = retired_q + 1'b1;
          if (is_hlt) begin
            state_d        = ST_IDLE;
            phase_d        = 3'd0;
            stop_flag_d    = 1'b1;
            stop_pending_d = 1'b0;
          end else if (stop_pending_q || exec_rise || step_stop) begin
            state_d        = ST_IDLE;
            phase_d        = 3'd0;
            stop_pending_d = 1'b0;
          end else begin
            phase_d = 3'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    sif.phase     = phase_q;
    sif.running   = (phase_q != 3'd0);
    sif.stop_flag = stop_flag_q;
    sif.retired   = retired_q;
  end

endmodule

`default_nettype wire

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Multicycle phase generator and run/stop controller for the 16-bit processor.
- Drives the `phase` bus and `stop_flag` into the combinational control decoder.
- Starts and stops execution from the `exec` button and halts on a decoded HLT.
- Counts retired instructions.
- Phase 0 is the idle phase, during which the decoder drives all enables to zero. Phases 1..NUM_PHASES are the active instruction phases.

Parameters:
- NUM_PHASES, 5, number of active phases per instruction; legal range 2..7; phase values 1..NUM_PHASES.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- exec  input  1  run/stop button level, already synchronised to clk; rising edge is the event.
- instruction  input  16  current IR contents, valid from phase 2 onward.
- step_mode  input  1  single-instruction mode select; used only with the optional feature.
- phase  output  3  current phase; 0 = idle, 1..NUM_PHASES = active.
- running  output  1  high while phase != 0.
- stop_flag  output  1  one-cycle pulse on the cycle phase returns to 0 because of HLT.
- retired  output  CNT_W  count of instructions whose last phase completed.

Behaviour:
- Reset: phase=0, running=0, stop_flag=0, retired=0, exec edge register=0, stop_pending=0. rst has priority over every other event, including mid-instruction; the partial instruction is abandoned and not counted.
- exec_rise = exec & ~exec_q, where exec_q is registered every cycle.
- HLT decode: instruction[15:14]==2'b11 and instruction[7:4]==4'b1111. Sampled only in the last phase.
- States: IDLE (phase==0) and RUN (phase 1..NUM_PHASES).
- IDLE:
  - exec_rise -> phase=1 next cycle; running=1 that same cycle.
  - Otherwise hold at 0.
- RUN, phase p < NUM_PHASES: phase=p+1.
  - exec_rise sets stop_pending.
  - No other effect; the instruction always completes.
- RUN, phase == NUM_PHASES (last phase):
  - retired increments by 1; wraps from all-ones to 0 without a flag.
  - If HLT: phase=0, stop_flag=1 for exactly one cycle, stop_pending cleared.
  - Else if stop_pending, or exec_rise in this same cycle: phase=0, stop_pending cleared, stop_flag stays 0.
  - Else: phase=1. No idle bubble between instructions.
  - HLT is counted as retired.
- exec_rise in the same cycle as rst: ignored.
- exec held high: only one edge is counted; a new press requires exec to go low first.
- Latency: exec_rise in IDLE to phase==1 is 1 cycle. Back-to-back instructions take exactly NUM_PHASES cycles each.
- After an HLT stop, an exec_rise restarts at phase 1. PC is untouched by this block, so execution resumes after the HLT.
- stop_flag and phase are registered outputs; running is phase != 0, derived from the register.
- Phase values above NUM_PHASES are unreachable; if one is ever reached, next phase=0.

Optional Feature:
- Macro: PHASE_SEQ_SINGLE_STEP_EN.
- Defined: when step_mode=1, the last phase always transitions to phase=0, as if stop_pending were set. One instruction executes per exec press. retired and stop_flag behave as normal; HLT still pulses stop_flag. step_mode is sampled in the last phase only.
- Not defined: step_mode is ignored (port kept, unconnected internally). Only exec presses and HLT stop the sequencer.

Test Plan:
- rst high 2 cycles, then low, exec=0 for 10 cycles -> phase=0, running=0, retired=0, stop_flag=0 throughout.
- Single exec pulse, instruction=16'h0000 (ADD), NUM_PHASES=5 -> phase goes 1,2,3,4,5,1,2,... continuously. retired=3 after 15 active cycles.
- Running; instruction switched to 16'hC0F0 (HLT) during phase 3 -> after phase 5, phase=0. stop_flag high exactly 1 cycle. retired incremented by 1. No further phases until the next exec edge.
- exec pulse during phase 2 -> phase runs 3,4,5 then 0, with no stop_flag. A second exec pulse restarts at phase 1.
- Assert rst during phase 3 -> next cycle phase=0, retired unchanged from its pre-instruction value.
- With PHASE_SEQ_SINGLE_STEP_EN and step_mode=1: three exec pulses -> exactly 15 active cycles total and retired=3. With retired preset by running 65535 instructions, the next retire gives retired=0.
